// File: rtl/gray_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter; each beat selects its own direction.
// Latency: STAGES cycles from input accept to output valid; one beat per cycle.
// Backpressure: stage k advances when empty or when stage k+1 advances; in_ready
//   is stage 0's advance term (combinational from out_ready), so bubbles collapse.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_data/in_mode      word to convert; mode 0 = Gray->binary, 1 = binary->Gray
//   in_valid/in_ready    input handshake
//   out_data/out_mode    converted word and the mode it was converted with
//   out_valid/out_ready  output handshake
module gray_conv_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_mode,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Bits resolved per stage, MSB-first. Trailing stages may get an empty
  // slice when DATA_WIDTH does not divide evenly; they simply pass through.
  localparam int SLICE = (DATA_WIDTH + STAGES - 1) / STAGES;

  // Resolve Gray bits hi..lo (clipped to the word) given the running parity
  // of everything above hi. Bits outside the slice are returned untouched.
  function automatic logic [DATA_WIDTH-1:0] resolve_slice(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  p,
    input int                    hi,
    input int                    lo
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  c;
    r = d;
    c = p;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (i <= hi && i >= lo) begin
        c    = c ^ r[i];
        r[i] = c;
      end
    end
    return r;
  endfunction

  // Binary-to-Gray has no carry chain, so it is finished at stage 0 and the
  // result rides the remaining stages untouched to keep both modes aligned.
  logic [DATA_WIDTH-1:0] w_b2g;
  assign w_b2g = in_data ^ (in_data >> 1);

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HI = DATA_WIDTH - 1 - k * SLICE;
    localparam int LO = DATA_WIDTH - (k + 1) * SLICE;

    logic                  r_vld;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_dat;

    logic                  w_src_vld;
    logic                  w_src_mode;
    logic                  w_src_par;
    logic [DATA_WIDTH-1:0] w_src_dat;
    logic [DATA_WIDTH-1:0] w_nxt_dat;
    logic                  w_adv;

    if (k == 0) begin : g_head
      assign w_src_vld  = in_valid;
      assign w_src_mode = in_mode;
      assign w_src_dat  = in_mode ? w_b2g : in_data;
      assign w_src_par  = 1'b0;
    end else begin : g_body
      assign w_src_vld  = g_stg[k-1].r_vld;
      assign w_src_mode = g_stg[k-1].r_mode;
      assign w_src_dat  = g_stg[k-1].r_dat;
      // The running parity of the upper slices equals the lowest bit the
      // previous stage resolved, so it is read back from the word instead of
      // being stored separately.
      if (HI >= 0) begin : g_par
        localparam int PAR_BIT = HI + 1;
        assign w_src_par = g_stg[k-1].r_dat[PAR_BIT];
      end else begin : g_nopar
        assign w_src_par = 1'b0;
      end
    end

    if (k == STAGES - 1) begin : g_tail_adv
      assign w_adv = !r_vld || out_ready;
    end else begin : g_mid_adv
      assign w_adv = !r_vld || g_stg[k+1].w_adv;
    end

    assign w_nxt_dat = w_src_mode ? w_src_dat
                                  : resolve_slice(w_src_dat, w_src_par, HI, LO);

    // Payload only loads when a real beat arrives, so an idle or stalled
    // stage keeps its contents stable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_mode <= 1'b0;
        r_dat  <= '0;
      end else if (w_adv) begin
        r_vld <= w_src_vld;
        if (w_src_vld) begin
          r_mode <= w_src_mode;
          r_dat  <= w_nxt_dat;
        end
      end
    end
  end

  assign in_ready  = g_stg[0].w_adv;
  assign out_valid = g_stg[STAGES-1].r_vld;
  assign out_mode  = g_stg[STAGES-1].r_mode;
  assign out_data  = g_stg[STAGES-1].r_dat;

endmodule

// File: tb/tb_gray_conv_pipe.sv
module tb_gray_conv_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a: 8-bit, 2 stages   b: 8-bit, 3 stages   c: 32-bit, 4 stages   d: 64-bit, 2 stages
  logic [7:0]  a_in_data, a_out_data;
  logic        a_in_mode, a_in_valid, a_in_ready, a_out_mode, a_out_valid, a_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic        b_in_mode, b_in_valid, b_in_ready, b_out_mode, b_out_valid, b_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic        c_in_mode, c_in_valid, c_in_ready, c_out_mode, c_out_valid, c_out_ready;
  logic [63:0] d_in_data, d_out_data;
  logic        d_in_mode, d_in_valid, d_in_ready, d_out_mode, d_out_valid, d_out_ready;

  gray_conv_pipe #(.DATA_WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_mode(a_in_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_mode(a_out_mode), .out_valid(a_out_valid), .out_ready(a_out_ready));

  gray_conv_pipe #(.DATA_WIDTH(8), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_mode(b_in_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_mode(b_out_mode), .out_valid(b_out_valid), .out_ready(b_out_ready));

  gray_conv_pipe #(.DATA_WIDTH(32), .STAGES(4)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_mode(c_in_mode),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_mode(c_out_mode), .out_valid(c_out_valid), .out_ready(c_out_ready));

  gray_conv_pipe #(.DATA_WIDTH(64), .STAGES(2)) u_d (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_mode(d_in_mode),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .out_data(d_out_data),
    .out_mode(d_out_mode), .out_valid(d_out_valid), .out_ready(d_out_ready));

  // Reference: plain MSB-first prefix XOR over the low w bits.
  function automatic logic [63:0] g2b_ref(input logic [63:0] x, input int w);
    logic [63:0] r;
    logic        p;
    r = '0;
    p = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      p    = p ^ x[i];
      r[i] = p;
    end
    return r;
  endfunction

  function automatic logic [63:0] b2g_ref(input logic [63:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_mode !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b dat=%h mode=%b want 0/00/0",
               a_out_valid, a_out_data, a_out_mode);
    end
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({a_in_ready, b_in_ready, c_in_ready, d_in_ready} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1111",
               {a_in_ready, b_in_ready, c_in_ready, d_in_ready});
    end
    checks++;
    if ({a_out_valid, b_out_valid, c_out_valid, d_out_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0000",
               {a_out_valid, b_out_valid, c_out_valid, d_out_valid});
    end
  endtask

  task automatic test_basic();
    logic [7:0] vin  [5];
    logic       vmode[5];
    logic [7:0] vexp [5];
    vin   = '{8'hC8, 8'hFF, 8'h80, 8'h8F, 8'hAA};
    vmode = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vexp  = '{8'h8F, 8'hAA, 8'hFF, 8'hC8, 8'hFF};
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_data  = vin[i];
      a_in_mode  = vmode[i];
      a_in_valid = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic_in_ready[%0d] got=%b want=1", i, a_in_ready);
      end
      tick();
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_early[%0d] out_valid got=%b want=0", i, a_out_valid);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== vexp[i] || a_out_mode !== vmode[i]) begin
        failures++;
        $display("FAIL basic_result[%0d] got vld=%b dat=%h mode=%b want 1/%h/%b",
                 i, a_out_valid, a_out_data, a_out_mode, vexp[i], vmode[i]);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [7:0] sin  [512];
    logic       smode[512];
    logic [7:0] sexp [512];
    logic [63:0] t;
    for (int w = 0; w < 256; w++) begin
      t = b2g_ref(64'(w));
      sin[2*w]     = 8'(w);
      smode[2*w]   = 1'b1;
      sexp[2*w]    = t[7:0];
      // Feed the Gray code back in: must return the original word.
      sin[2*w+1]   = t[7:0];
      smode[2*w+1] = 1'b0;
      sexp[2*w+1]  = 8'(w);
    end
    a_out_ready = 1'b1;
    for (int j = 0; j < 514; j++) begin
      if (j == 1) begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_fill out_valid got=%b want=0", a_out_valid);
        end
      end else if (j >= 2) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== sexp[j-2] || a_out_mode !== smode[j-2]) begin
          failures++;
          $display("FAIL stream[%0d] got vld=%b dat=%h mode=%b want 1/%h/%b",
                   j - 2, a_out_valid, a_out_data, a_out_mode, sexp[j-2], smode[j-2]);
        end
      end
      if (j < 512) begin
        a_in_data  = sin[j];
        a_in_mode  = smode[j];
        a_in_valid = 1'b1;
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  bvec [5];
    logic        bmode[5];
    logic [7:0]  bexp [5];
    logic [63:0] t;
    int idx, got;
    logic in_acc, out_take;
    bvec  = '{8'h11, 8'h22, 8'hC8, 8'h80, 8'h5A};
    bmode = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      t = bmode[i] ? b2g_ref(64'(bvec[i])) : g2b_ref(64'(bvec[i]), 8);
      bexp[i] = t[7:0];
    end
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      b_out_ready = (cyc >= 9);
      b_in_valid  = (idx < 5);
      if (idx < 5) begin
        b_in_data = bvec[idx];
        b_in_mode = bmode[idx];
      end
      #1;
      in_acc   = b_in_valid && b_in_ready;
      out_take = b_out_valid && b_out_ready;
      if (cyc == 8) begin
        checks++;
        if (idx != 3 || b_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_accept_count got accepted=%0d in_ready=%b want 3/0",
                   idx, b_in_ready);
        end
      end
      if (cyc >= 3 && cyc < 9) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== bexp[0] || b_out_mode !== bmode[0]) begin
          failures++;
          $display("FAIL bp_frozen[cyc %0d] got vld=%b dat=%h mode=%b want 1/%h/%b",
                   cyc, b_out_valid, b_out_data, b_out_mode, bexp[0], bmode[0]);
        end
      end
      if (out_take) begin
        checks++;
        if (b_out_data !== bexp[got] || b_out_mode !== bmode[got]) begin
          failures++;
          $display("FAIL bp_order[%0d] got dat=%h mode=%b want %h/%b",
                   got, b_out_data, b_out_mode, bexp[got], bmode[got]);
        end
        got++;
      end
      tick();
      if (in_acc) idx++;
    end
    b_in_valid = 1'b0;
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL bp_drain got beats=%0d want=5", got);
    end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_mode   = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h33;
    tick();
    a_in_data   = 8'h44;
    tick();
    a_in_valid  = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_full out_valid got=%b want=1", a_out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async got vld=%b dat=%h want 0/00", a_out_valid, a_out_data);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    a_out_ready = 1'b1;
    a_in_data   = 8'h01;
    a_in_mode   = 1'b0;
    a_in_valid  = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_first_clock got in_ready=%b out_valid=%b want 1/0",
               a_in_ready, a_out_valid);
    end
    tick();
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_stale out_valid got=%b want=0", a_out_valid);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'h01 || a_out_mode !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_new_beat got vld=%b dat=%h mode=%b want 1/01/0",
               a_out_valid, a_out_data, a_out_mode);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after out_valid got=%b want=0", a_out_valid);
    end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] e;
    logic [63:0] t;
    int sent, recv;
    logic in_acc, out_take;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 30000 && recv < 2000; cyc++) begin
      c_in_valid  = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      c_in_data   = 32'($urandom);
      c_in_mode   = 1'($urandom_range(0, 1));
      c_out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (q.size() > 4) begin
        failures++;
        $display("FAIL rand_inflight got=%0d want<=4", q.size());
      end
      in_acc   = c_in_valid && c_in_ready;
      out_take = c_out_valid && c_out_ready;
      if (out_take) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_duplicate got dat=%h want no beat", c_out_data);
        end else begin
          e = q.pop_front();
          if ({c_out_mode, c_out_data} !== e) begin
            failures++;
            $display("FAIL rand_beat[%0d] got mode=%b dat=%h want %b/%h",
                     recv, c_out_mode, c_out_data, e[32], e[31:0]);
          end
        end
        recv++;
      end
      if (in_acc) begin
        t = c_in_mode ? b2g_ref(64'(c_in_data)) : g2b_ref(64'(c_in_data), 32);
        q.push_back({c_in_mode, t[31:0]});
        sent++;
      end
      tick();
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b0;
    checks++;
    if (recv != 2000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain got recv=%0d left=%0d want 2000/0", recv, q.size());
    end
  endtask

  task automatic test_wide();
    logic [63:0] vin [2];
    logic        vmode[2];
    logic [63:0] vexp [2];
    vin   = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vmode = '{1'b0, 1'b1};
    vexp  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    d_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_in_data  = vin[i];
      d_in_mode  = vmode[i];
      d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      tick();
      checks++;
      if (d_out_valid !== 1'b1 || d_out_data !== vexp[i] || d_out_mode !== vmode[i]) begin
        failures++;
        $display("FAIL wide[%0d] got vld=%b dat=%h mode=%b want 1/%h/%b",
                 i, d_out_valid, d_out_data, d_out_mode, vexp[i], vmode[i]);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    a_in_data = '0; a_in_mode = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_data = '0; c_in_mode = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    d_in_data = '0; d_in_mode = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
